// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the combinational program ROM and
// presents one instruction at a time to decode. Unconditional jumps are folded here.
module fetch_unit #(
    parameter int unsigned         ADDR_W   = 12,
    parameter int unsigned         INSTR_W  = 16,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0,
    parameter logic [3:0]          JMP_OP   = 4'b1010
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  code_address,
    input  logic [INSTR_W-1:0] instruction,
    output logic [INSTR_W-1:0] ir,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt,
    output logic               spin,
    output logic [15:0]        fetch_count
);

    logic [ADDR_W-1:0] pc_q;
    logic [3:0]        opcode;
    logic [ADDR_W-1:0] jmp_target;
    logic              accept;
    logic              slot_open;

    assign opcode       = instruction[INSTR_W-1 -: 4];
    assign jmp_target   = instruction[ADDR_W-1:0];
    assign accept       = ir_valid & ir_ready;
    assign slot_open    = ~ir_valid | ir_ready;
    assign code_address = pc_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            ir          <= '0;
            ir_pc       <= '0;
            ir_valid    <= 1'b0;
            spin        <= 1'b0;
            fetch_count <= '0;
        end else begin
            // A flushed instruction that decode accepted still counts as delivered.
            if (accept) begin
                fetch_count <= fetch_count + 16'd1;
            end

            if (redirect) begin
                pc_q     <= redirect_pc;
                ir_valid <= 1'b0;
                spin     <= 1'b0;
            end else if (halt) begin
                if (accept) begin
                    ir_valid <= 1'b0;
                end
            end else if (slot_open) begin
                if (opcode == JMP_OP) begin
                    pc_q     <= jmp_target;
                    ir_valid <= 1'b0;
                    spin     <= (jmp_target == pc_q);
                end else begin
                    ir       <= instruction;
                    ir_pc    <= pc_q;
                    ir_valid <= 1'b1;
                    pc_q     <= pc_q + 1'b1;
                    spin     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios from the ROM program, then randomized traffic,
// all checked cycle by cycle against a reference model of the fetch rules.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] code_address;
    logic [15:0] instruction;
    logic [15:0] ir;
    logic [11:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect;
    logic [11:0] redirect_pc;
    logic        halt;
    logic        spin;
    logic [15:0] fetch_count;

    // Second instance with a reset PC at the top of the address space.
    logic        w_rst_n;
    logic [11:0] w_code_address;
    logic [15:0] w_ir;
    logic [11:0] w_ir_pc;
    logic        w_ir_valid;
    logic        w_spin;
    logic [15:0] w_fetch_count;

    logic [15:0] rom [4096];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference state
    logic [11:0] m_pc;
    logic [15:0] m_ir;
    logic [11:0] m_ir_pc;
    logic        m_valid;
    logic        m_spin;
    logic [15:0] m_count;

    always #5 clk = ~clk;

    assign instruction = rom[code_address];

    fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .code_address (code_address),
        .instruction  (instruction),
        .ir           (ir),
        .ir_pc        (ir_pc),
        .ir_valid     (ir_valid),
        .ir_ready     (ir_ready),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .halt         (halt),
        .spin         (spin),
        .fetch_count  (fetch_count)
    );

    fetch_unit #(.RESET_PC(12'hFFF)) dut_w (
        .clk          (clk),
        .rst_n        (w_rst_n),
        .code_address (w_code_address),
        .instruction  (16'h1234),
        .ir           (w_ir),
        .ir_pc        (w_ir_pc),
        .ir_valid     (w_ir_valid),
        .ir_ready     (1'b1),
        .redirect     (1'b0),
        .redirect_pc  (12'h000),
        .halt         (1'b0),
        .spin         (w_spin),
        .fetch_count  (w_fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Apply one cycle of inputs, advance the model by the fetch rules, then compare.
    task automatic step(input logic rstn, input logic rdy, input logic redir,
                        input logic [11:0] rpc, input logic hlt);
        logic [15:0] word;
        logic        acc;
        rst_n       = rstn;
        ir_ready    = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        halt        = hlt;
        word        = rom[m_pc];
        if (!rstn) begin
            m_pc = 12'h000; m_ir = '0; m_ir_pc = '0; m_valid = 0; m_spin = 0; m_count = '0;
        end else begin
            acc = m_valid && rdy;
            if (acc) m_count = m_count + 16'd1;
            if (redir) begin
                m_pc = rpc; m_valid = 0; m_spin = 0;
            end else if (hlt) begin
                if (acc) m_valid = 0;
            end else if (!m_valid || rdy) begin
                if (word[15:12] == 4'hA) begin
                    m_spin  = (word[11:0] == m_pc);
                    m_pc    = word[11:0];
                    m_valid = 0;
                end else begin
                    m_ir = word; m_ir_pc = m_pc; m_valid = 1; m_spin = 0;
                    m_pc = m_pc + 12'd1;
                end
            end
        end
        @(posedge clk);
        #1;
        check("code_address", 32'(code_address), 32'(m_pc));
        check("ir_valid",     32'(ir_valid),     32'(m_valid));
        check("ir",           32'(ir),           32'(m_ir));
        check("ir_pc",        32'(ir_pc),        32'(m_ir_pc));
        check("spin",         32'(spin),         32'(m_spin));
        check("fetch_count",  32'(fetch_count),  32'(m_count));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1, 1, 0, 12'h0, 0);
    endtask

    initial begin
        w_rst_n = 1'b0;
        m_pc = '0; m_ir = '0; m_ir_pc = '0; m_valid = 0; m_spin = 0; m_count = '0;
        for (int i = 0; i < 4096; i++) rom[i] = 16'h0000;
        rom[0] = 16'hD204; rom[1] = 16'h2203; rom[2] = 16'hC200;
        rom[3] = 16'h3333; rom[4] = 16'hA003; rom[5] = 16'hA005;

        // Reset and straight-line stream with folded jump back to 3
        step(0, 1, 0, 12'h0, 0);
        step(0, 1, 0, 12'h0, 0);
        check("rst_addr", 32'(code_address), 32'h000);
        check("rst_valid", 32'(ir_valid), 32'h0);
        check("rst_count", 32'(fetch_count), 32'h0);
        run(1); check("seq0", 32'(ir), 32'hD204);
        run(1); check("seq1", 32'(ir), 32'h2203);
        run(1); check("seq2", 32'(ir), 32'hC200);
        run(1); check("seq3", 32'(ir), 32'h3333);
        run(1); check("bubble", 32'(ir_valid), 32'h0);
        check("bubble_addr", 32'(code_address), 32'h003);
        run(1); check("rep_pc", 32'(ir_pc), 32'h003);
        run(6);

        // Backpressure on 2203
        step(0, 1, 0, 12'h0, 0);
        run(2);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 12'h0, 0);
            check("bp_ir", 32'(ir), 32'h2203);
            check("bp_addr", 32'(code_address), 32'h002);
        end
        run(1); check("bp_release", 32'(ir), 32'hC200);

        // Redirect while 2203 is accepted
        step(0, 1, 0, 12'h0, 0);
        run(2);
        step(1, 1, 1, 12'h002, 0);
        check("redir_valid", 32'(ir_valid), 32'h0);
        check("redir_count", 32'(fetch_count), 32'h2);
        run(1); check("redir_tgt", 32'(ir), 32'hC200);

        // Jump-to-self, then escape
        step(1, 1, 1, 12'h005, 0);
        for (int i = 0; i < 5; i++) begin
            run(1); check("spin_hold", 32'(spin), 32'h1);
        end
        step(1, 1, 1, 12'h000, 0);
        check("spin_clear", 32'(spin), 32'h0);
        run(1); check("spin_resume", 32'(ir), 32'hD204);

        // Halt mid-stream
        run(1);
        step(1, 0, 0, 12'h0, 1);
        step(1, 1, 0, 12'h0, 1);
        check("halt_pc", 32'(code_address), 32'h002);
        check("halt_drain", 32'(ir_valid), 32'h0);
        run(1); check("halt_resume", 32'(ir), 32'hC200);

        // Reset pulse mid-stream
        run(3);
        step(0, 1, 0, 12'h0, 0);
        check("pulse_count", 32'(fetch_count), 32'h0);
        run(3);

        // Wrap 0xFFF -> 0x000 via redirect
        step(1, 1, 1, 12'hFFF, 0);
        run(1); check("wrap_ff", 32'(ir_pc), 32'hFFF);
        run(1); check("wrap_00", 32'(ir_pc), 32'h000);

        // Randomized program and traffic
        for (int i = 0; i < 4096; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(15, 0));
            if ($urandom_range(4, 0) == 0) rom[i] = {4'hA, 12'($urandom)};
            else rom[i] = {(op == 4'hA) ? 4'h0 : op, 12'($urandom)};
        end
        step(0, 1, 0, 12'h0, 0);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(49, 0) != 0, $urandom_range(3, 0) != 0,
                 $urandom_range(19, 0) == 0, 12'($urandom), $urandom_range(9, 0) == 0);
        end

        // Reset-PC wrap on the second instance
        @(posedge clk); #1;
        check("w_rst_addr", 32'(w_code_address), 32'hFFF);
        w_rst_n = 1'b1;
        @(posedge clk); #1;
        check("w_pc_ff", 32'(w_ir_pc), 32'hFFF);
        @(posedge clk); #1;
        check("w_pc_00", 32'(w_ir_pc), 32'h000);
        check("w_valid", 32'(w_ir_valid), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the 16-bit CPU. It owns the program counter, drives the 12-bit `code_address` into the combinational program ROM, and captures the returned `instruction` into an instruction register. It hands that register to the decode stage over a valid/ready handshake. Unconditional jumps (opcode 1010) are folded in fetch and never reach decode; execute can redirect the PC for taken branches.

## Interface
- `ADDR_W`, 12, code address width
- `INSTR_W`, 16, instruction width
- `RESET_PC`, 12'h000, PC value after reset
- `JMP_OP`, 4'b1010, opcode (`instruction[15:12]`) folded as unconditional jump; target is `instruction[11:0]`

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `code_address`  out  12  ROM address, driven directly from the PC register
- `instruction`  in  16  ROM data, combinational from `code_address` in the same cycle
- `ir`  out  16  instruction presented to decode
- `ir_pc`  out  12  address `ir` was fetched from
- `ir_valid`  out  1  `ir`/`ir_pc` hold a valid instruction
- `ir_ready`  in  1  decode accepts `ir` this cycle
- `redirect`  in  1  execute-stage PC override (taken branch)
- `redirect_pc`  in  12  new PC when `redirect`=1
- `halt`  in  1  freeze fetch; no new instruction is loaded
- `spin`  out  1  fetch is stuck on a jump-to-self
- `fetch_count`  out  16  number of instructions delivered to decode (accepted handshakes), wrapping

## Operation
- Reset (`rst_n`=0 at edge): PC=`RESET_PC`, `ir`=0, `ir_pc`=0, `ir_valid`=0, `spin`=0, `fetch_count`=0. Reset overrides every other input.
- Load slot is open when `ir_valid`=0, or when `ir_valid`=1 and `ir_ready`=1.
- Per-edge priority, highest first:
  1. `redirect`=1: PC←`redirect_pc`, `ir_valid`←0 (flush, including an instruction being accepted this cycle), `spin`←0. The ROM word at the old PC is discarded. If the flushed slot was being accepted, `fetch_count` still increments.
  2. `halt`=1: PC and `ir` hold. `ir_valid` clears only if it is accepted this cycle.
  3. Load slot is open and `instruction[15:12]`==`JMP_OP`: PC←`instruction[11:0]` and `ir_valid`←0 (bubble). `spin`←1 iff the target equals the current PC, otherwise 0.
  4. Load slot is open, other opcode: `ir`←`instruction`, `ir_pc`←PC, `ir_valid`←1, PC←PC+1 mod 4096 (4095 wraps to 0), `spin`←0.
  5. Otherwise (IR full, `ir_ready`=0): all state holds.
- `fetch_count` increments by 1 (mod 65536) on every cycle with `ir_valid`=1 and `ir_ready`=1.
- `ir`/`ir_pc` must not change while `ir_valid`=1 and `ir_ready`=0.
- Jump-to-self re-executes every cycle with `spin`=1 until a redirect or reset occurs.

## Timing
- `code_address` changes only on clock edges; the ROM has zero-cycle latency.
- Load latency: the word at PC appears on `ir` the cycle after that PC is driven.
- Throughput: 1 instruction/cycle when `ir_ready` is held high and there are no jumps.
- Folded jump: exactly 1 bubble cycle (`ir_valid`=0). The target instruction is valid 2 cycles after the jump address was driven.
- Redirect at edge N: `code_address`=`redirect_pc` and `ir_valid`=0 during cycle N+1; the target instruction is valid in cycle N+2.
- `halt` deasserted at edge N: fetch resumes at edge N+1 with the held PC.

## Test plan
- Reset release, ROM = {0:D204, 1:2203, 2:C200, 3:xxxx, 4:A003}, `ir_ready`=1:
  - `ir` sequence D204, 2203, C200, word3.
  - Bubble at address 4.
  - Then word3 again with `ir_pc`=3, repeating.
  - `fetch_count` increments once per valid cycle.
- Backpressure: hold `ir_ready`=0 for 3 cycles while `ir`=2203 → `ir`, `ir_pc`=1 and `code_address`=2 stay stable. On release, C200 follows the next cycle with no skipped or duplicate instruction.
- Redirect to 12'h002 in the same cycle `ir`=2203 is accepted → cycle after: `ir_valid`=0, `code_address`=2. The following cycle: `ir`=C200, `ir_pc`=2. `fetch_count` counts the accepted 2203.
- Jump-to-self (ROM[5]=A005, PC=5) → `spin`=1 and `ir_valid`=0 indefinitely. Redirect to 0 clears `spin` and resumes at D204.
- Wrap: `RESET_PC`=12'hFFF with non-jump words → `ir_pc` goes FFF, then 000.
- `halt` asserted for 2 cycles mid-stream, and `rst_n`=0 pulsed mid-stream:
  - During halt: PC frozen, `ir_valid` clears once the held instruction is accepted.
  - Reset pulse: the next cycle shows `code_address`=`RESET_PC` and `ir_valid`=0, with counters cleared.
